// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic feeder: FSM states, sequence lengths and
// flat-row element extraction.
package systolic_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StDone
   } feed_state_e;

   // Upper bounds for the generic row/element helper below.
   localparam int unsigned MAX_ROW_W  = 1024;
   localparam int unsigned MAX_ELEM_W = 64;

   function automatic int unsigned feed_beats(input int unsigned size);
      return 2 * size - 1;
   endfunction

   function automatic int unsigned drain_beats(input int unsigned size);
      return size;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned size);
      return $clog2(3 * size + 1);
   endfunction

   // Element k of a flat row whose elements are dw bits wide.
   function automatic logic [MAX_ELEM_W-1:0] lane_elem(input logic [MAX_ROW_W-1:0] row,
                                                       input int unsigned k,
                                                       input int unsigned dw);
      logic [MAX_ELEM_W-1:0] mask;
      mask = (MAX_ELEM_W'(1) << dw) - MAX_ELEM_W'(1);
      return MAX_ELEM_W'(row >> (k * dw)) & mask;
   endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed lane: at beat t it presents element t-LANE of its vector, or zero outside
// the lane's active window.
module systolic_skew_lane
   import systolic_pkg::*;
#(
   parameter int unsigned LANE       = 0,
   parameter int unsigned SIZE       = 3,
   parameter int unsigned DATA_WIDTH = 10,
   localparam int unsigned CNT_W     = cnt_width(SIZE)
) (
   input  logic [CNT_W-1:0]           beat,
   input  logic [SIZE*DATA_WIDTH-1:0] vec,
   output logic [DATA_WIDTH-1:0]      elem
);

   int idx;

   always_comb begin
      elem = '0;
      idx  = int'(beat) - int'(LANE);
      if (idx >= 0 && idx < int'(SIZE)) begin
         elem = DATA_WIDTH'(lane_elem(MAX_ROW_W'(vec), unsigned'(idx), DATA_WIDTH));
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Operand store and skewed-wavefront driver for the systolic matrix-multiply array:
// clear, feed 2*SIZE-1 skewed beats, drain SIZE zero beats, then pulse done.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned SIZE       = 3,
   parameter int unsigned DATA_WIDTH = 10,
   localparam int unsigned IDX_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_en,
   input  logic                       load_sel,
   input  logic [IDX_W-1:0]           load_idx,
   input  logic [SIZE*DATA_WIDTH-1:0] load_data,
   input  logic                       start,
   output logic [SIZE*DATA_WIDTH-1:0] a_out,
   output logic [SIZE*DATA_WIDTH-1:0] b_out,
   output logic                       feed_valid,
   output logic                       acc_clr,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned ROW_W       = SIZE * DATA_WIDTH;
   localparam int unsigned CNT_W       = cnt_width(SIZE);
   localparam int unsigned FEED_BEATS  = feed_beats(SIZE);
   localparam int unsigned DRAIN_BEATS = drain_beats(SIZE);

   feed_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] a_mem_q [SIZE];
   logic [ROW_W-1:0] b_mem_q [SIZE];
   logic [ROW_W-1:0] b_col   [SIZE];
   logic [ROW_W-1:0] a_lane, b_lane;
   logic             load_ok;

   assign load_ok = (state_q == StIdle) && load_en && (32'(load_idx) < SIZE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < int'(SIZE); r++) begin
            a_mem_q[r] <= '0;
            b_mem_q[r] <= '0;
         end
      end else if (load_ok) begin
         if (load_sel) b_mem_q[load_idx] <= load_data;
         else          a_mem_q[load_idx] <= load_data;
      end
   end

   // Column j of B, element k taken from row k.
   always_comb begin
      for (int j = 0; j < int'(SIZE); j++) begin
         b_col[j] = '0;
         for (int k = 0; k < int'(SIZE); k++) begin
            b_col[j][k*DATA_WIDTH +: DATA_WIDTH] = b_mem_q[k][j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Lanes are indexed by the next beat so the registered outputs line up with state_d.
   for (genvar g = 0; g < int'(SIZE); g++) begin : g_lane
      systolic_skew_lane #(
         .LANE       (g),
         .SIZE       (SIZE),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_a_lane (
         .beat (cnt_d),
         .vec  (a_mem_q[g]),
         .elem (a_lane[g*DATA_WIDTH +: DATA_WIDTH])
      );
      systolic_skew_lane #(
         .LANE       (g),
         .SIZE       (SIZE),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_b_lane (
         .beat (cnt_d),
         .vec  (b_col[g]),
         .elem (b_lane[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: if (start) state_d = StClear;
         StClear: begin
            state_d = StFeed;
            cnt_d   = '0;
         end
         StFeed: begin
            if (cnt_q == CNT_W'(FEED_BEATS - 1)) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == CNT_W'(DRAIN_BEATS - 1)) state_d = StDone;
            else                                  cnt_d   = cnt_q + 1'b1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         a_out      <= '0;
         b_out      <= '0;
         feed_valid <= 1'b0;
         acc_clr    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_out      <= (state_d == StFeed) ? a_lane : '0;
         b_out      <= (state_d == StFeed) ? b_lane : '0;
         feed_valid <= (state_d == StFeed);
         acc_clr    <= (state_d == StClear);
         busy       <= (state_d == StClear) || (state_d == StFeed) || (state_d == StDrain);
         done       <= (state_d == StDone);
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: a matrix model fills a per-cycle scoreboard at
// each start, and every cycle of the sequence is popped and compared.
module tb_systolic_feeder;

   localparam int SIZE  = 3;
   localparam int DW    = 10;
   localparam int IDX_W = 2;
   localparam int RW    = SIZE * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_en;
   logic          load_sel;
   logic [IDX_W-1:0] load_idx;
   logic [RW-1:0] load_data;
   logic          start;
   logic [RW-1:0] a_out, b_out;
   logic          feed_valid, acc_clr, busy, done;

   systolic_feeder #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_sel   (load_sel),
      .load_idx   (load_idx),
      .load_data  (load_data),
      .start      (start),
      .a_out      (a_out),
      .b_out      (b_out),
      .feed_valid (feed_valid),
      .acc_clr    (acc_clr),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [RW-1:0] a;
      logic [RW-1:0] b;
      logic          fv;
      logic          clr;
      logic          bz;
      logic          dn;
   } exp_t;

   exp_t sb[$];
   int   ma[SIZE][SIZE];
   int   mb[SIZE][SIZE];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [RW-1:0] pack3(input int e0, input int e1, input int e2);
      return {DW'(e2), DW'(e1), DW'(e0)};
   endfunction

   task automatic model_write(input bit sel, input int idx, input logic [RW-1:0] row);
      if (idx < SIZE) begin
         for (int k = 0; k < SIZE; k++) begin
            if (sel) mb[idx][k] = int'(row[k*DW +: DW]);
            else     ma[idx][k] = int'(row[k*DW +: DW]);
         end
      end
   endtask

   // Expected outputs for cycles E0 .. E(3*SIZE) of one accepted start.
   task automatic push_seq();
      exp_t e;
      int   t;
      for (int c = 0; c <= 3 * SIZE; c++) begin
         e = '0;
         if (c == 0) begin
            e.clr = 1'b1;
            e.bz  = 1'b1;
         end else if (c <= 2 * SIZE - 1) begin
            t    = c - 1;
            e.fv = 1'b1;
            e.bz = 1'b1;
            for (int i = 0; i < SIZE; i++) begin
               if (t - i >= 0 && t - i < SIZE) begin
                  e.a[i*DW +: DW] = DW'(ma[i][t-i]);
                  e.b[i*DW +: DW] = DW'(mb[t-i][i]);
               end
            end
         end else if (c < 3 * SIZE) begin
            e.bz = 1'b1;
         end else begin
            e.dn = 1'b1;
         end
         sb.push_back(e);
      end
   endtask

   task automatic load_row(input bit sel, input int idx, input logic [RW-1:0] row);
      @(negedge clk);
      load_en   = 1'b1;
      load_sel  = sel;
      load_idx  = IDX_W'(idx);
      load_data = row;
      model_write(sel, idx, row);
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic run_seq(input string tag, input bit ld0, input bit ld0_sel, input int ld0_idx,
                          input logic [RW-1:0] ld0_row, input int inj_load_c,
                          input int inj_start_c);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      if (ld0) begin
         load_en   = 1'b1;
         load_sel  = ld0_sel;
         load_idx  = IDX_W'(ld0_idx);
         load_data = ld0_row;
         model_write(ld0_sel, ld0_idx, ld0_row);
      end
      push_seq();
      for (int c = 0; c <= 3 * SIZE; c++) begin
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("%s c%0d a_out", tag, c), a_out, e.a);
         chk($sformatf("%s c%0d b_out", tag, c), b_out, e.b);
         chk($sformatf("%s c%0d feed_valid", tag, c), RW'(feed_valid), RW'(e.fv));
         chk($sformatf("%s c%0d acc_clr", tag, c), RW'(acc_clr), RW'(e.clr));
         chk($sformatf("%s c%0d busy", tag, c), RW'(busy), RW'(e.bz));
         chk($sformatf("%s c%0d done", tag, c), RW'(done), RW'(e.dn));
         start   = 1'b0;
         load_en = 1'b0;
         if (c + 1 == inj_load_c) begin
            load_en   = 1'b1;
            load_sel  = 1'b0;
            load_idx  = '0;
            load_data = pack3(99, 99, 99);
         end
         if (c + 1 == inj_start_c) start = 1'b1;
      end
      @(negedge clk);
      chk({tag, " idle busy"}, RW'(busy), '0);
      chk({tag, " idle done"}, RW'(done), '0);
   endtask

   initial begin
      rst       = 1'b0;
      load_en   = 1'b0;
      load_sel  = 1'b0;
      load_idx  = '0;
      load_data = '0;
      start     = 1'b0;
      for (int i = 0; i < SIZE; i++)
         for (int k = 0; k < SIZE; k++) begin
            ma[i][k] = 0;
            mb[i][k] = 0;
         end
      #1;
      chk("reset a_out", a_out, '0);
      chk("reset b_out", b_out, '0);
      chk("reset feed_valid", RW'(feed_valid), '0);
      chk("reset acc_clr", RW'(acc_clr), '0);
      chk("reset busy", RW'(busy), '0);
      chk("reset done", RW'(done), '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Load operands, start, then reset during beat 2.
      for (int r = 0; r < SIZE; r++) begin
         load_row(1'b0, r, pack3(3 * r + 1, 3 * r + 2, 3 * r + 3));
         load_row(1'b1, r, pack3(3 * r + 10, 3 * r + 11, 3 * r + 12));
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("midfeed feed_valid", RW'(feed_valid), RW'(1));
      rst = 1'b0;
      #1;
      chk("rst a_out", a_out, '0);
      chk("rst b_out", b_out, '0);
      chk("rst feed_valid", RW'(feed_valid), '0);
      chk("rst busy", RW'(busy), '0);
      repeat (3) begin
         @(negedge clk);
         chk("rst held done", RW'(done), '0);
      end
      rst = 1'b1;
      for (int i = 0; i < SIZE; i++)
         for (int k = 0; k < SIZE; k++) begin
            ma[i][k] = 0;
            mb[i][k] = 0;
         end
      repeat (4) begin
         @(negedge clk);
         chk("post rst done", RW'(done), '0);
      end
      run_seq("zero", 1'b0, 1'b0, 0, '0, -1, -1);

      for (int r = 0; r < SIZE; r++) begin
         load_row(1'b0, r, pack3(3 * r + 1, 3 * r + 2, 3 * r + 3));
         load_row(1'b1, r, pack3(3 * r + 10, 3 * r + 11, 3 * r + 12));
      end
      run_seq("skew", 1'b0, 1'b0, 0, '0, -1, -1);
      // Load during FEED (edge E2) and start during DRAIN (edge E7) must both be ignored.
      run_seq("prot", 1'b0, 1'b0, 0, '0, 2, 7);
      run_seq("reprot", 1'b0, 1'b0, 0, '0, -1, -1);
      run_seq("same", 1'b1, 1'b1, 0, pack3(20, 21, 22), -1, -1);
      load_row(1'b0, 3, pack3(50, 51, 52));
      load_row(1'b1, 3, pack3(60, 61, 62));
      run_seq("oor", 1'b0, 1'b0, 0, '0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Source-side partner of the systolic matrix-multiply array.
- Stores two SIZE x SIZE operand matrices, A and B, loaded row by row over a simple write port.
- On start, clears the array accumulators. It then drives the skewed wavefront: row lane i of A is delayed by i cycles, and column lane j of B by j cycles. Zero flush beats follow so the far PE finishes.
- Signals completion with a one-cycle done pulse, so the array's own cycle counter is not needed.

Parameters:
- SIZE, 3, array dimension (square, SIZE >= 2).
- DATA_WIDTH, 10, width of one matrix element.
- IDX_W, $clog2(SIZE) (min 1), width of load row index; derived localparam.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low.
- load_en  input  1  write one operand row this cycle.
- load_sel  input  1  0 = matrix A, 1 = matrix B.
- load_idx  input  IDX_W  row index to write.
- load_data  input  SIZE*DATA_WIDTH  row contents; element k at [k*DATA_WIDTH +: DATA_WIDTH].
- start  input  1  begin one feed sequence.
- a_out  output  SIZE*DATA_WIDTH  A wavefront; lane i drives array row i.
- b_out  output  SIZE*DATA_WIDTH  B wavefront; lane j drives array column j.
- feed_valid  output  1  high while a data beat (not a flush beat) is on a_out/b_out.
- acc_clr  output  1  one-cycle synchronous accumulator clear for the array.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - a_out, b_out, feed_valid, acc_clr, busy and done all go to 0.
  - Both matrix stores are cleared to 0.
  - Reset mid-sequence aborts it immediately; no done pulse is produced.
- All outputs are registered.
- Loading:
  - Accepted only in IDLE. The write occurs at the sampling edge: row load_idx of the selected matrix takes load_data.
  - load_idx >= SIZE is ignored.
  - load_en while busy is ignored and the store is unchanged.
- start is sampled in IDLE only; start while busy is ignored.
- load_en and start in the same IDLE cycle: both are honoured, and the feed uses the newly written row.
- Timing, with E0 the edge that samples start:
  - CLEAR: from E0, acc_clr=1 and busy=1 for exactly one cycle; a_out and b_out are 0.
  - FEED: beat t = 0 .. 2*SIZE-2 is driven from edge E(1+t). feed_valid=1 throughout.
    - a_out lane i = A[i][t-i] if 0 <= t-i < SIZE, else 0.
    - b_out lane j = B[t-j][j] if 0 <= t-j < SIZE, else 0.
  - DRAIN: SIZE beats from E(2*SIZE) to E(3*SIZE-1). a_out, b_out and feed_valid are all 0.
  - DONE: at E(3*SIZE), done=1 for one cycle and busy=0, then back to IDLE. done is never asserted in two consecutive cycles.
  - busy is high for exactly 3*SIZE cycles, from E0 through E(3*SIZE-1).
- Beat counter:
  - Width $clog2(3*SIZE+1).
  - Resets to 0 on entry to FEED and again on entry to DRAIN.
  - No wrap-around is reachable.
- The stored matrices are unchanged by a sequence, so back-to-back starts re-feed identical data.
- A new start is accepted in the DONE cycle's following IDLE cycle at the earliest.
- There is no arithmetic and no width growth; elements pass through unmodified.

Decomposition:
- Shared package systolic_pkg:
  - State enum (IDLE, CLEAR, FEED, DRAIN, DONE).
  - Lane slice helper function: element k of a flat row.
  - Localparams FEED_BEATS = 2*SIZE-1 and DRAIN_BEATS = SIZE.
- Sub-module systolic_skew_lane (parameters LANE, SIZE, DATA_WIDTH):
  - Given beat t and the lane's stored vector, it outputs element t-LANE or 0.
  - It is instantiated SIZE times for A, fed row i, and SIZE times for B, fed column j gathered from the B rows.
- Top level holds the FSM, the counter and the storage.

Test Plan (SIZE=3, DATA_WIDTH=10 throughout):
- Reset mid-FEED:
  - Stimulus: start, then rst low at beat 2.
  - Response: all outputs 0 immediately, busy=0, no done pulse.
  - Check: after release, a start with no loads feeds all-zero beats.
- Basic skew:
  - Stimulus: load A=[[1,2,3],[4,5,6],[7,8,9]] and B=[[10,11,12],[13,14,15],[16,17,18]], then start.
  - CLEAR: acc_clr=1 for one cycle.
  - A lanes (lane0,lane1,lane2) per beat: t0 (1,0,0); t1 (2,4,0); t2 (3,5,7); t3 (0,6,8); t4 (0,0,9).
  - B lanes per beat: t0 (10,0,0); t1 (13,11,0); t2 (16,14,12); t3 (0,17,15); t4 (0,0,18).
- Sequence timing:
  - Response: feed_valid high for 5 cycles, then 3 zero drain beats.
  - busy high for 9 cycles; done pulses for exactly 1 cycle, coinciding with busy falling.
- Busy protection:
  - Stimulus: load_en with load_sel=0, load_idx=0, data (99,99,99) during FEED, plus start during DRAIN.
  - Response: both ignored; re-start shows A row 0 still (1,2,3); exactly one done pulse per accepted start.
- Same-cycle load and start:
  - Stimulus: load B row 0 = (20,21,22) together with start in IDLE.
  - Response: beat t0 b_out lane0 = 20.
- Out-of-range index:
  - Stimulus: load_idx=3.
  - Response: no store change; the next feed matches the prior data.
